bp_me_cce_addr_checker: RTL and testbench

- CCE-side ingress check for incoming memory-command addresses; the receiving end of the requester-side address-to-CCE-ID mapping.
- Classifies each incoming paddr into the local, DRAM or coprocessor region and recomputes the owning CCE ID. It compares that ID against this CCE's ID and compacts DRAM addresses by removing the bank-stripe bits.
- Buffers results in a 2-entry FIFO toward the CCE pipeline and counts misrouted requests.

---
 rtl/bp_me_cce_addr_checker.sv | 131 +++++++++++++
 tb/tb_bp_me_cce_addr_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bp_me_cce_addr_checker.sv
// CCE ingress address checker: region decode, owner recompute, DRAM
// address compaction, 2-entry output FIFO and misroute counter.
module bp_me_cce_addr_checker #(
    parameter int paddr_width_p = 40,
    parameter int cce_id_width_p = 6,
    parameter int num_cce_p = 4,
    parameter int block_width_p = 512,
    parameter logic [paddr_width_p-1:0] dram_base_addr_p = 'h00_8000_0000,
    parameter logic [paddr_width_p-1:0] coproc_base_addr_p = 'h10_0000_0000,
    parameter int cce_lsb_p = 16,
    parameter int tag_width_p = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [cce_id_width_p-1:0] cce_id_i,
    input  logic                      v_i,
    input  logic [paddr_width_p-1:0]  addr_i,
    input  logic [tag_width_p-1:0]    tag_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [paddr_width_p-1:0]  addr_o,
    output logic [tag_width_p-1:0]    tag_o,
    output logic                      match_o,
    input  logic                      yumi_i,
    output logic [15:0]               err_count_o
);

    localparam int bo_lp = $clog2(block_width_p/8);
    localparam int lg_lp = (num_cce_p > 1) ? $clog2(num_cce_p) : 0;
    localparam int entry_w_lp = paddr_width_p + tag_width_p + 1;

    logic                      w_is_local;
    logic                      w_is_coproc;
    logic                      w_is_dram;
    logic [cce_id_width_p-1:0] w_dram_owner;
    logic [paddr_width_p-1:0]  w_dram_addr;
    logic [cce_id_width_p-1:0] w_owner;
    logic [paddr_width_p-1:0]  w_addr;
    logic                      w_match;
    logic                      w_enq;
    logic                      w_deq;
    logic [entry_w_lp-1:0]     w_head;

    logic [entry_w_lp-1:0]     r_mem [2];
    logic                      r_wptr;
    logic                      r_rptr;
    logic [1:0]                r_count;
    logic [15:0]               r_err;

    assign w_is_local  = (addr_i < dram_base_addr_p);
    assign w_is_coproc = (addr_i >= coproc_base_addr_p);
    assign w_is_dram   = !w_is_local && !w_is_coproc;

    // Bank-stripe bits sit just above the block offset
    if (lg_lp > 0) begin : g_striped
        assign w_dram_owner = {{(cce_id_width_p-lg_lp){1'b0}},
                               addr_i[bo_lp +: lg_lp]};
        assign w_dram_addr  = {{lg_lp{1'b0}},
                               addr_i[paddr_width_p-1:bo_lp+lg_lp],
                               addr_i[bo_lp-1:0]};
    end else begin : g_single
        assign w_dram_owner = '0;
        assign w_dram_addr  = addr_i;
    end

    always_comb begin
        w_owner = '0;
        w_addr  = addr_i;
        unique case (1'b1)
            w_is_local: begin
                w_owner = addr_i[cce_lsb_p +: cce_id_width_p];
                w_addr  = addr_i;
            end
            w_is_dram: begin
                w_owner = w_dram_owner;
                w_addr  = w_dram_addr;
            end
            default: begin
                w_owner = '0;
                w_addr  = addr_i;
            end
        endcase
    end

    assign w_match = !w_is_coproc && (w_owner == cce_id_i);

    assign ready_o = reset_n_i && (r_count != 2'd2);
    assign v_o     = (r_count != 2'd0);
    assign w_enq   = v_i && ready_o;
    assign w_deq   = yumi_i && v_o;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr] <= {w_addr, tag_i, w_match};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_err   <= 16'd0;
        end else begin
            if (w_enq) r_wptr <= ~r_wptr;
            if (w_deq) r_rptr <= ~r_rptr;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_enq && !w_match && (r_err != 16'hFFFF)) begin
                r_err <= r_err + 16'd1;
            end
        end
    end

    assign w_head      = r_mem[r_rptr];
    assign addr_o      = v_o ? w_head[entry_w_lp-1 -: paddr_width_p] : '0;
    assign tag_o       = v_o ? w_head[tag_width_p:1] : '0;
    assign match_o     = v_o ? w_head[0] : 1'b0;
    assign err_count_o = r_err;

    // Consumer must only take a valid head
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_o));
        end
    end

endmodule

// File: tb/tb_bp_me_cce_addr_checker.sv
// Directed self-checking bench for bp_me_cce_addr_checker.
module tb_bp_me_cce_addr_checker;

    logic        clk;
    logic        reset_n;
    logic [5:0]  cce_id;
    logic        v_i;
    logic [39:0] addr_i;
    logic [7:0]  tag_i;
    logic        ready_o;
    logic        v_o;
    logic [39:0] addr_o;
    logic [7:0]  tag_o;
    logic        match_o;
    logic        yumi_i;
    logic [15:0] err_count_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_err = 16'd0;

    bp_me_cce_addr_checker dut (
        .clk_i(clk), .reset_n_i(reset_n), .cce_id_i(cce_id),
        .v_i(v_i), .addr_i(addr_i), .tag_i(tag_i), .ready_o(ready_o),
        .v_o(v_o), .addr_o(addr_o), .tag_o(tag_o), .match_o(match_o),
        .yumi_i(yumi_i), .err_count_o(err_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [39:0] a, input logic [7:0] t);
        v_i = 1'b1; addr_i = a; tag_i = t;
        tick();
        v_i = 1'b0;
    endtask

    task automatic pop();
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; v_i = 1'b1; addr_i = 40'h10_0000_0000; tag_i = 8'h5A;
        tick(); tick();
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", ready_o); end
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rst_v got %b want 0", v_o); end
        n_cmp++; if (addr_o !== 40'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", addr_o); end
        n_cmp++; if (tag_o !== 8'h0) begin n_err++; $display("FAIL rst_tag got %h want 0", tag_o); end
        n_cmp++; if (match_o !== 1'b0) begin n_err++; $display("FAIL rst_match got %b want 0", match_o); end
        n_cmp++; if (err_count_o !== 16'h0) begin n_err++; $display("FAIL rst_err got %h want 0", err_count_o); end
        v_i = 1'b0; reset_n = 1'b1;
        tick();
        exp_err = 16'h0;
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready_after got %b want 1", ready_o); end
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL rst_dropped_v got %b want 0", v_o); end
    endtask

    task automatic test_dram();
        logic [39:0] a  [4] = '{40'h00_8000_0080, 40'h00_8000_00C0, 40'h00_8000_0000, 40'h0F_FFFF_FFFF};
        logic [39:0] ea [4] = '{40'h00_2000_0000, 40'h00_2000_0000, 40'h00_2000_0000, 40'h03_FFFF_FFFF};
        logic        em [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        cce_id = 6'd2;
        for (int i = 0; i < 4; i++) begin
            send(a[i], 8'h11 + 8'(i));
            if (!em[i]) exp_err = exp_err + 16'd1;
            n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL dram%0d_v got %b want 1", i, v_o); end
            n_cmp++; if (match_o !== em[i]) begin n_err++; $display("FAIL dram%0d_match got %b want %b", i, match_o, em[i]); end
            n_cmp++; if (addr_o !== ea[i]) begin n_err++; $display("FAIL dram%0d_addr got %h want %h", i, addr_o, ea[i]); end
            n_cmp++; if (tag_o !== 8'h11 + 8'(i)) begin n_err++; $display("FAIL dram%0d_tag got %h want %h", i, tag_o, 8'h11 + 8'(i)); end
            n_cmp++; if (err_count_o !== exp_err) begin n_err++; $display("FAIL dram%0d_err got %h want %h", i, err_count_o, exp_err); end
            pop();
            n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL dram%0d_drain got %b want 0", i, v_o); end
        end
    endtask

    task automatic test_local();
        logic [39:0] a  [3] = '{40'h00_0003_0040, 40'h00_0004_0000, 40'h00_7FFF_FFFF};
        logic        em [3] = '{1'b1, 1'b0, 1'b0};
        cce_id = 6'd3;
        for (int i = 0; i < 3; i++) begin
            send(a[i], 8'h20 + 8'(i));
            if (!em[i]) exp_err = exp_err + 16'd1;
            n_cmp++; if (match_o !== em[i]) begin n_err++; $display("FAIL local%0d_match got %b want %b", i, match_o, em[i]); end
            n_cmp++; if (addr_o !== a[i]) begin n_err++; $display("FAIL local%0d_addr got %h want %h", i, addr_o, a[i]); end
            n_cmp++; if (err_count_o !== exp_err) begin n_err++; $display("FAIL local%0d_err got %h want %h", i, err_count_o, exp_err); end
            pop();
        end
    endtask

    task automatic test_coproc();
        logic [39:0] a [3] = '{40'h10_0000_0000, 40'h10_0002_0080, 40'hFF_FFFF_FFFF};
        cce_id = 6'd2;
        for (int i = 0; i < 3; i++) begin
            send(a[i], 8'h30 + 8'(i));
            exp_err = exp_err + 16'd1;
            n_cmp++; if (match_o !== 1'b0) begin n_err++; $display("FAIL coproc%0d_match got %b want 0", i, match_o); end
            n_cmp++; if (addr_o !== a[i]) begin n_err++; $display("FAIL coproc%0d_addr got %h want %h", i, addr_o, a[i]); end
            n_cmp++; if (err_count_o !== exp_err) begin n_err++; $display("FAIL coproc%0d_err got %h want %h", i, err_count_o, exp_err); end
            pop();
        end
    endtask

    task automatic test_back_to_back();
        cce_id = 6'd2;
        v_i = 1'b1; addr_i = 40'h00_8000_0080; tag_i = 8'hA1;
        tick();
        addr_i = 40'h00_8000_0180; tag_i = 8'hB2;
        tick();
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", ready_o); end
        addr_i = 40'h00_8000_0280; tag_i = 8'hC3;
        tick();
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_held_ready got %b want 0", ready_o); end
        n_cmp++; if (tag_o !== 8'hA1) begin n_err++; $display("FAIL bp_head0 got %h want a1", tag_o); end
        pop();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop got %b want 1", ready_o); end
        n_cmp++; if (tag_o !== 8'hB2) begin n_err++; $display("FAIL bp_head1 got %h want b2", tag_o); end
        n_cmp++; if (addr_o !== 40'h00_2000_0040) begin n_err++; $display("FAIL bp_addr1 got %h want 0020000040", addr_o); end
        tick();
        v_i = 1'b0;
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL bp_refill_ready got %b want 0", ready_o); end
        n_cmp++; if (tag_o !== 8'hB2) begin n_err++; $display("FAIL bp_head_stable got %h want b2", tag_o); end
        pop();
        n_cmp++; if (tag_o !== 8'hC3) begin n_err++; $display("FAIL bp_head2 got %h want c3", tag_o); end
        v_i = 1'b1; addr_i = 40'h00_8000_0380; tag_i = 8'hD4; yumi_i = 1'b1;
        tick();
        v_i = 1'b0; yumi_i = 1'b0;
        n_cmp++; if (v_o !== 1'b1) begin n_err++; $display("FAIL bp_simul_v got %b want 1", v_o); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL bp_simul_ready got %b want 1", ready_o); end
        n_cmp++; if (tag_o !== 8'hD4) begin n_err++; $display("FAIL bp_simul_head got %h want d4", tag_o); end
        n_cmp++; if (match_o !== 1'b1) begin n_err++; $display("FAIL bp_simul_match got %b want 1", match_o); end
        pop();
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", v_o); end
        n_cmp++; if (err_count_o !== exp_err) begin n_err++; $display("FAIL bp_err got %h want %h", err_count_o, exp_err); end
    endtask

    task automatic test_saturation();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        v_i = 1'b1; addr_i = 40'h10_0000_0000; tag_i = 8'hEE;
        tick();
        yumi_i = 1'b1;
        repeat (65533) tick();
        v_i = 1'b0;
        tick();
        yumi_i = 1'b0;
        n_cmp++; if (err_count_o !== 16'hFFFE) begin n_err++; $display("FAIL sat_preload got %h want fffe", err_count_o); end
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL sat_drain got %b want 0", v_o); end
        send(40'h10_0000_0000, 8'hE1);
        n_cmp++; if (err_count_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_max got %h want ffff", err_count_o); end
        send(40'h10_0000_0000, 8'hE2);
        n_cmp++; if (err_count_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", err_count_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL sat_full got %b want 0", ready_o); end
        reset_n = 1'b0;
        tick();
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL midrst_v got %b want 0", v_o); end
        n_cmp++; if (err_count_o !== 16'h0) begin n_err++; $display("FAIL midrst_err got %h want 0", err_count_o); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", ready_o); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL postrst_ready got %b want 1", ready_o); end
        n_cmp++; if (v_o !== 1'b0) begin n_err++; $display("FAIL postrst_v got %b want 0", v_o); end
    endtask

    initial begin
        reset_n = 1'b0; cce_id = 6'd2; v_i = 1'b0; yumi_i = 1'b0;
        addr_i = '0; tag_i = '0;
        test_reset();
        test_dram();
        test_local();
        test_coproc();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
